riscv_if: RTL and testbench
===========================

// Module: riscv_if
// PURPOSE
//  Instruction-fetch stage. Sits directly upstream of riscv_id and supplies its instruction/pc inputs.
//  Issues in-order word fetches to instruction memory over a req/gnt/rvalid handshake.
//  Buffers returned words in a small FIFO, tagged with their PC.
//  Honours redirects from branch/jump resolution by flushing and discarding stale responses.
// PARAMETERS
//  XLEN      32   data/address width
//  RESET_PC  0    first fetch address after reset
//  DEPTH     2    instruction buffer entries; also max in-flight + buffered words (power of 2, >=2)
// PORTS
//  clk          in   1     clock; all state updates on posedge
//  rst          in   1     synchronous, active-high reset
//  imem_req     out  1     fetch request valid
//  imem_addr    out  XLEN  fetch address (word aligned)
//  imem_gnt     in   1     request accepted this cycle (handshake = req & gnt)
//  imem_rvalid  in   1     response valid; responses return in order, >=1 cycle after gnt
//  imem_rdata   in   XLEN  response instruction word
//  redirect     in   1     flush pipeline and restart fetch at redirect_pc
//  redirect_pc  in   XLEN  new fetch target
//  id_ready     in   1     decode consumes head entry this cycle
//  id_valid     out  1     head entry valid
//  instruction  out  XLEN  head instruction; `INSN_NOP (32'h00000013) when !id_valid
//  pc           out  XLEN  PC of head instruction
//  misaligned   out  1     sticky: last redirect target had pc[1:0]!=0
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - fetch_pc=resp_pc=RESET_PC; outstanding=discard=0; FIFO empty; misaligned=0.
//   - Outputs: imem_req=0, id_valid=0, instruction=NOP, pc=RESET_PC.
//   - Reset mid-transaction abandons in-flight responses. Memory is reset with the core.
//  Request:
//   - imem_req = !rst_q & !redirect & !misaligned & (outstanding + fifo_count < DEPTH).
//   - imem_addr = fetch_pc. On req&gnt: fetch_pc += 4 (wraps mod 2^XLEN), outstanding++.
//   - imem_req is first high the cycle after rst deasserts.
//  Response:
//   - Each rvalid: outstanding--.
//   - If discard>0: drop the word, discard--.
//   - Else: push {resp_pc, imem_rdata} into the FIFO, resp_pc += 4.
//   - Credit rule guarantees a push never hits a full FIFO; assert this.
//  Output:
//   - id_valid = !empty. Word visible the cycle after its rvalid (registered push).
//   - Pop when id_valid & id_ready. Push and pop in the same cycle are both honoured.
//   - Counters update simultaneously for gnt and rvalid in the same cycle (net 0).
//  Redirect (highest priority, single cycle):
//   - FIFO flushed; fetch_pc <= resp_pc <= {redirect_pc[XLEN-1:2],2'b00}.
//   - discard <= outstanding - rvalid. Any rvalid that cycle is also dropped.
//   - Any pop that cycle is void. imem_req=0 that cycle, so no gnt is possible.
//   - misaligned <= |redirect_pc[1:0]. While misaligned=1: no requests, id_valid=0.
//   - misaligned clears only on an aligned redirect or reset.
//  Throughput: with gnt tied high and 1-cycle memory, DEPTH=2 sustains 1 instruction/cycle.
// STRUCTURE
//  - Shared isa.v: XLEN default, `INSN_NOP constant, PC step constant 4.
//  - Sub-module riscv_if_fifo: sync FIFO, parameters WIDTH/DEPTH.
//    Ports push, pop, flush, full, empty, count, head. Flush dominates push/pop.
//  - Counters outstanding, discard: $clog2(DEPTH)+1 bits.
// TESTING
//  1. Reset release, gnt=1, 1-cycle memory returning addr-derived data
//     -> addrs 0,4,8...; id_valid from cycle 3; pc/instruction pairs match; 1/cycle.
//  2. id_ready=0 for 5 cycles -> FIFO fills to 2; imem_req drops with outstanding+count=2.
//     id_ready=1 -> resumes, no word lost or duplicated.
//  3. Redirect to 0x100 with 2 words in flight
//     -> both stale rvalids dropped; first valid output pc=0x100; FIFO empty the cycle after redirect.
//  4. Redirect to 0x102 -> misaligned=1, imem_req=0, id_valid=0.
//     Later redirect to 0x200 -> misaligned=0, fetch from 0x200.
//  5. gnt withheld randomly, 3-cycle rvalid latency
//     -> in-order PCs; outstanding never exceeds DEPTH; push-on-full assertion never fires.
//  6. rst asserted while a word is in flight and FIFO full
//     -> next cycle id_valid=0, instruction=NOP, pc=RESET_PC; refetch from RESET_PC.

Source files
------------

// File: rtl/riscv_if_pkg.sv
// riscv_if_pkg: shared ISA constants for the fetch stage
package riscv_if_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [31:0] INSN_NOP = 32'h0000_0013;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/riscv_if_fifo.sv
// riscv_if_fifo: synchronous instruction buffer; flush dominates push/pop
module riscv_if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  assign count = wr - rd;
  assign empty = wr == rd;
  assign full = count == (AW+1)'(DEPTH);
  assign head = mem[rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full) begin
        mem[wr[AW-1:0]] <= din;
        wr <= wr + 1'b1;
      end
      if (pop && !empty) rd <= rd + 1'b1;
    end
  end
endmodule

// File: rtl/riscv_if.sv
// riscv_if: instruction fetch with credit-limited requests, PC-tagged buffer and redirect flush
module riscv_if
  import riscv_if_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic            misaligned
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic rst_q, full, empty, push, pop, hs;
  logic [XLEN-1:0] fetch_pc, resp_pc, target;
  logic [CW-1:0] outstanding, discard, count;
  logic [CW:0] inflight;
  logic [2*XLEN-1:0] head;
  assign target = {redirect_pc[XLEN-1:2], 2'b00};
  assign id_valid = !empty && !misaligned;
  assign pop = id_valid && id_ready && !redirect;
  // a same-cycle pop frees a slot, which is what lets DEPTH=2 sustain one fetch per cycle
  assign inflight = (CW+1)'(outstanding) + (CW+1)'(count) - (CW+1)'(pop);
  assign imem_req = !rst_q && !redirect && !misaligned && (inflight < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign hs = imem_req && imem_gnt;
  assign push = imem_rvalid && !redirect && discard == '0;
  assign instruction = id_valid ? head[XLEN-1:0] : XLEN'(INSN_NOP);
  assign pc = id_valid ? head[2*XLEN-1:XLEN] : resp_pc;
  riscv_if_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(redirect),
    .din({resp_pc, imem_rdata}), .full(full), .empty(empty), .count(count), .head(head)
  );
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
      misaligned <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= target;
      resp_pc <= target;
      outstanding <= outstanding - CW'(imem_rvalid);
      discard <= outstanding - CW'(imem_rvalid);
      misaligned <= |redirect_pc[1:0];
    end else begin
      if (hs) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      if (push) resp_pc <= resp_pc + XLEN'(PC_STEP);
      outstanding <= outstanding + CW'(hs) - CW'(imem_rvalid);
      if (imem_rvalid && discard != '0) discard <= discard - 1'b1;
    end
  end
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_credit: assert property (@(posedge clk) disable iff (rst) outstanding <= CW'(DEPTH));
endmodule

// File: tb/tb_riscv_if.sv
// tb_riscv_if: randomized fetch-stage bench against a PC-stream reference model
module tb_riscv_if;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1, imem_gnt = 0, imem_rvalid = 0, redirect = 0, id_ready = 0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
  logic imem_req, id_valid, misaligned;
  logic [31:0] imem_addr, instruction, pc;
  int n_tests = 0, n_fail = 0, cyc = 0, gnt_pct = 100, ready_pct = 100, lat = 1, consumed = 0;
  logic [31:0] exp_pc = '0, exp_fetch = '0, last_pc = '0;
  logic exp_mis = 0;
  logic [31:0] qa[$];
  int qd[$];

  riscv_if dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .id_valid(id_valid),
    .instruction(instruction), .pc(pc), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // one clock: drive memory/consumer, observe, update the model, advance to next negedge
  task automatic tick();
    imem_gnt = $urandom_range(99) < gnt_pct;
    id_ready = $urandom_range(99) < ready_pct;
    imem_rvalid = 0;
    imem_rdata = '0;
    if (qa.size() > 0 && qd[0] <= cyc) begin
      imem_rvalid = 1;
      imem_rdata = mem_word(qa[0]);
      void'(qa.pop_front());
      void'(qd.pop_front());
    end
    #1;
    if (rst) begin
      qa.delete();
      qd.delete();
      exp_pc = '0;
      exp_fetch = '0;
      exp_mis = 0;
    end else begin
      chk("misaligned", misaligned, exp_mis);
      if (exp_mis) begin
        chk("mis_req", imem_req, 0);
        chk("mis_valid", id_valid, 0);
      end
      if (redirect) begin
        chk("redir_req", imem_req, 0);
        exp_pc = {redirect_pc[31:2], 2'b00};
        exp_fetch = exp_pc;
        exp_mis = |redirect_pc[1:0];
      end else begin
        if (id_valid && id_ready) begin
          chk("out_pc", pc, exp_pc);
          chk("out_insn", instruction, mem_word(exp_pc));
          last_pc = pc;
          exp_pc += 4;
          consumed++;
        end
        if (imem_req && imem_gnt) begin
          chk("fetch_addr", imem_addr, exp_fetch);
          exp_fetch += 4;
          qa.push_back(imem_addr);
          qd.push_back(cyc + lat);
          chk("inflight_le_depth", 32'(qa.size() <= DEPTH), 1);
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    redirect = 0;
    #1;
  endtask

  task automatic wait_consume(input string name, input logic [31:0] first);
    int c0 = consumed;
    for (int i = 0; i < 40 && consumed == c0; i++) tick();
    chk({name, "_progress"}, 32'(consumed > c0), 1);
    chk({name, "_first_pc"}, last_pc, first);
  endtask

  task automatic test_reset();
    rst = 1;
    gnt_pct = 100; ready_pct = 100; lat = 1;
    repeat (3) tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_insn", instruction, 32'h13);
    chk("rst_pc", pc, 0);
    chk("rst_mis", misaligned, 0);
  endtask

  task automatic test_stream();
    rst = 0;
    #1;
    chk("req_release0", imem_req, 0);
    tick();
    chk("req_release1", imem_req, 1);
    chk("addr_first", imem_addr, 0);
    tick();
    tick();
    chk("valid_cycle3", id_valid, 1);
    chk("pc_cycle3", pc, 0);
    for (int i = 0; i < 12; i++) begin
      chk("throughput_valid", id_valid, 1);
      tick();
    end
  endtask

  task automatic test_backpressure();
    int c0;
    ready_pct = 0;
    repeat (5) tick();
    chk("bp_valid", id_valid, 1);
    chk("bp_req", imem_req, 0);
    chk("bp_inflight", 32'(qa.size()), 0);
    ready_pct = 100;
    c0 = consumed;
    repeat (10) tick();
    chk("bp_resume", 32'(consumed - c0 >= 8), 1);
  endtask

  task automatic test_redirect();
    lat = 3;
    for (int i = 0; i < 20 && qa.size() != 2; i++) tick();
    chk("redir_inflight2", 32'(qa.size()), 2);
    redirect = 1;
    redirect_pc = 32'h100;
    tick();
    chk("redir_empty", id_valid, 0);
    wait_consume("redir", 32'h100);
  endtask

  task automatic test_misaligned();
    redirect = 1;
    redirect_pc = 32'h102;
    tick();
    chk("mis_set", misaligned, 1);
    chk("mis_req_now", imem_req, 0);
    chk("mis_valid_now", id_valid, 0);
    repeat (6) tick();
    redirect = 1;
    redirect_pc = 32'h200;
    tick();
    chk("mis_clear", misaligned, 0);
    chk("mis_refetch_req", imem_req, 1);
    chk("mis_refetch_addr", imem_addr, 32'h200);
    wait_consume("mis", 32'h200);
  endtask

  task automatic test_random();
    int c0 = consumed;
    gnt_pct = 50; ready_pct = 70; lat = 3;
    redirect = 1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 3) begin
        redirect = 1;
        redirect_pc = $urandom & 32'hFFFF_FFFC;
      end
      tick();
    end
    chk("rand_progress", 32'(consumed - c0 > 40), 1);
  endtask

  task automatic test_reset_midflight();
    gnt_pct = 100; ready_pct = 0; lat = 3;
    for (int i = 0; i < 20 && !(id_valid && qa.size() > 0); i++) tick();
    chk("mid_setup", 32'(id_valid && qa.size() > 0), 1);
    rst = 1;
    tick();
    chk("mid_valid", id_valid, 0);
    chk("mid_insn", instruction, 32'h13);
    chk("mid_pc", pc, 0);
    chk("mid_req", imem_req, 0);
    rst = 0;
    ready_pct = 100;
    #1;
    wait_consume("mid", 32'h0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
